// File: rtl/cpu_pkg.sv
// Shared datapath types and constants for the CPU core.
// Words use big-endian bit order: index 0 is the MSB.
package cpu_pkg;

  typedef logic [0:15] word_t;

  localparam logic  DIR_INC  = 1'b1;
  localparam logic  DIR_DEC  = 1'b0;
  localparam word_t WORD_MAX = 16'hFFFF;
  localparam int    NIB_W    = 4;

endpackage

// File: rtl/inc_nibble.sv
// One 4-bit slice of the +/-1 unit. Bit 0 is the slice MSB.
// The slice toggles each bit whose lower neighbours all match the direction.
module inc_nibble
  import cpu_pkg::*;
(
  input  logic [0:NIB_W-1] nib,
  input  logic             dir,
  input  logic             cin,
  output logic [0:NIB_W-1] res,
  output logic             prop
);

  logic [0:NIB_W-1] match;
  logic [0:NIB_W-1] tgl;

  // A bit "matches" when it would pass a carry (inc: 1) or a borrow (dec: 0).
  // The direction is used as-is so an unknown dir poisons the result.
  assign match = (dir == DIR_INC) ? nib : ~nib;

  assign tgl[3] = cin;
  assign tgl[2] = cin & match[3];
  assign tgl[1] = cin & match[3] & match[2];
  assign tgl[0] = cin & match[3] & match[2] & match[1];

  assign res  = nib ^ tgl;
  assign prop = &match;

endmodule

// File: rtl/incrementer.sv
// 16-bit +/-1 unit with zero-latency result, wrap flag and a registered copy.
// Nibble propagates feed a lookahead so every slice gets its carry in one level.
module incrementer
  import cpu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [0:WIDTH-1] i_in,
  input  logic             i_dir,
  output logic [0:WIDTH-1] o_out,
  output logic             o_wrap,
  output logic [0:WIDTH-1] o_out_q,
  output logic             o_wrap_q
);

  localparam int NIB = WIDTH / NIB_W;

  // Nibble j = 0 is the least-significant slice (highest bit indices).
  logic [NIB-1:0] prop;
  logic [NIB-1:0] cin;

  genvar j;
  generate
    for (j = 0; j < NIB; j++) begin : g_nib
      if (j == 0) begin : g_lsb
        assign cin[j] = 1'b1;
      end else begin : g_upper
        assign cin[j] = &prop[j-1:0];
      end

      inc_nibble u_nib (
        .nib  (i_in [WIDTH-NIB_W*(j+1) +: NIB_W]),
        .dir  (i_dir),
        .cin  (cin[j]),
        .res  (o_out[WIDTH-NIB_W*(j+1) +: NIB_W]),
        .prop (prop[j])
      );
    end
  endgenerate

  // Every slice passing the carry/borrow means the word wrapped.
  assign o_wrap = &prop;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_out_q  <= '0;
      o_wrap_q <= 1'b0;
    end else begin
      o_out_q  <= o_out;
      o_wrap_q <= o_wrap;
    end
  end

endmodule

// File: tb/tb_incrementer.sv
// Self-checking bench for the 16-bit +/-1 unit: directed table, registered
// path and reset sequences, random pipelined traffic and an exhaustive sweep.
module tb_incrementer;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  word_t       in_v;
  logic        dir;
  word_t       out_c;
  logic        wrap_c;
  word_t       out_q;
  logic        wrap_q;

  int unsigned n_vec  = 0;
  int unsigned n_fail = 0;

  incrementer #(.WIDTH(16)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_in     (in_v),
    .i_dir    (dir),
    .o_out    (out_c),
    .o_wrap   (wrap_c),
    .o_out_q  (out_q),
    .o_wrap_q (wrap_q)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] in;
    logic        dir;
    logic [15:0] out;
    logic        wrap;
  } vec_t;

  vec_t tbl[8];

  // Plain integer arithmetic: step by one, wrap when leaving 0..65535.
  function automatic void ref_model(input int x, input logic d,
                                    output logic [15:0] r, output logic w);
    int s;
    s = d ? x + 1 : x - 1;
    w = (s < 0) || (s > 65535);
    r = 16'((s + 65536) % 65536);
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  logic [15:0] e_out;
  logic        e_wrap;
  logic [15:0] y;

  initial begin
    tbl[0] = '{16'h0115, DIR_INC, 16'h0116, 1'b0};
    tbl[1] = '{16'h0114, DIR_DEC, 16'h0113, 1'b0};
    tbl[2] = '{16'h01FF, DIR_INC, 16'h0200, 1'b0};
    tbl[3] = '{16'h0041, DIR_DEC, 16'h0040, 1'b0};
    tbl[4] = '{WORD_MAX, DIR_INC, 16'h0000, 1'b1};
    tbl[5] = '{16'h0000, DIR_DEC, WORD_MAX, 1'b1};
    tbl[6] = '{16'h7FFF, DIR_INC, 16'h8000, 1'b0};
    tbl[7] = '{16'h8000, DIR_DEC, 16'h7FFF, 1'b0};

    rst_n = 1'b0;
    in_v  = 16'h1234;
    dir   = DIR_INC;

    // Reset state, and combinational path alive during reset.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_q", out_q, 16'h0000);
    chk("rst_wrap_q", {15'd0, wrap_q}, 16'h0000);
    chk("rst_comb_out", out_c, 16'h1235);

    // Directed table on the combinational outputs.
    for (int i = 0; i < 8; i++) begin
      in_v = tbl[i].in;
      dir  = tbl[i].dir;
      #1;
      chk($sformatf("tbl%0d_out", i), out_c, tbl[i].out);
      chk($sformatf("tbl%0d_wrap", i), {15'd0, wrap_c}, {15'd0, tbl[i].wrap});
    end

    // Registered path, then mid-operation reset.
    @(negedge clk);
    rst_n = 1'b1;
    in_v  = 16'h0FFF;
    dir   = DIR_INC;
    @(posedge clk); #1;
    chk("reg_out_q", out_q, 16'h1000);
    chk("reg_wrap_q", {15'd0, wrap_q}, 16'h0000);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_out_q", out_q, 16'h0000);
    chk("midrst_wrap_q", {15'd0, wrap_q}, 16'h0000);
    chk("midrst_comb", out_c, 16'h1000);
    @(negedge clk);
    rst_n = 1'b1;
    in_v  = WORD_MAX;
    @(posedge clk); #1;
    chk("resume_out_q", out_q, 16'h0000);
    chk("resume_wrap_q", {15'd0, wrap_q}, 16'h0001);
    @(negedge clk);
    in_v = 16'h0000;
    dir  = DIR_DEC;
    @(posedge clk); #1;
    chk("dec_wrap_out_q", out_q, 16'hFFFF);
    chk("dec_wrap_wrap_q", {15'd0, wrap_q}, 16'h0001);

    // Random pipelined traffic with occasional reset pulses.
    for (int i = 0; i < 300; i++) begin
      int x;
      logic d;
      logic r;
      @(negedge clk);
      case ($urandom_range(0, 7))
        0:       x = 0;
        1:       x = 65535;
        default: x = int'($urandom_range(0, 65535));
      endcase
      d = 1'($urandom_range(0, 1));
      r = ($urandom_range(0, 15) != 0);
      in_v  = 16'(x);
      dir   = d;
      rst_n = r;
      ref_model(x, d, e_out, e_wrap);
      if (!r) begin
        e_out  = 16'h0000;
        e_wrap = 1'b0;
      end
      @(posedge clk); #1;
      chk("rand_out_q", out_q, e_out);
      chk("rand_wrap_q", {15'd0, wrap_q}, {15'd0, e_wrap});
    end
    rst_n = 1'b1;

    // Exhaustive sweep: every value decremented, then the result incremented back.
    for (int x = 0; x < 65536; x++) begin
      in_v = 16'(x);
      dir  = DIR_DEC;
      #1;
      ref_model(x, 1'b0, e_out, e_wrap);
      chk("sweep_dec_out", out_c, e_out);
      chk("sweep_dec_wrap", {15'd0, wrap_c}, {15'd0, e_wrap});
      y    = out_c;
      in_v = y;
      dir  = DIR_INC;
      #1;
      ref_model(int'(y), 1'b1, e_out, e_wrap);
      chk("sweep_inc_out", out_c, e_out);
      chk("sweep_inc_wrap", {15'd0, wrap_c}, {15'd0, e_wrap});
      chk("sweep_roundtrip", out_c, 16'(x));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
